// File: rtl/dance_step_judge.sv
// Step-driven arrow judge: arms a target pattern on each new step, grades pad presses
// within WINDOW cycles, keeps a saturating score/combo. COMBO_BONUS_EN enables +2 hits at combo>=3.
module dance_step_judge #(
    parameter int unsigned WINDOW  = 4,
    parameter int unsigned SCORE_W = 8
) (
    input  logic               Clock,
    input  logic               reset,
    input  logic [2:0]         step,
    input  logic [3:0]         pads,
    output logic [3:0]         arrows,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         combo
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } state_t;

    localparam logic [3:0] WIN_LAST = 4'(WINDOW - 1);

    state_t             state;
    logic [2:0]         step_q;
    logic [3:0]         pattern;
    logic [3:0]         win_cnt;
    logic [3:0]         rom_pat;
    logic               beat;
    logic               judge_hit;
    logic               judge_miss;
    logic [SCORE_W:0]   score_inc;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;

    always_comb begin
        rom_pat = 4'b0000;
        case (step)
            3'd0: rom_pat = 4'b0001;
            3'd1: rom_pat = 4'b0010;
            3'd2: rom_pat = 4'b0100;
            3'd3: rom_pat = 4'b1000;
            3'd4: rom_pat = 4'b0011;
            3'd5: rom_pat = 4'b1100;
            3'd6: rom_pat = 4'b0101;
            3'd7: rom_pat = 4'b1010;
            default: rom_pat = 4'b0000;
        endcase
    end

    // A beat arriving while still armed forces a verdict on the old pattern first.
    always_comb begin
        beat       = (step != step_q);
        judge_hit  = 1'b0;
        judge_miss = 1'b0;
        if (state == ARMED) begin
            judge_hit  = (pads == pattern);
            judge_miss = !judge_hit &&
                         (((pads & ~pattern) != 4'b0000) || (win_cnt == WIN_LAST) || beat);
        end
    end

    always_comb begin
        score_inc = (SCORE_W + 1)'(1);
`ifdef COMBO_BONUS_EN
        if (combo >= 4'd3)
            score_inc = (SCORE_W + 1)'(2);
`endif
        score_sum  = {1'b0, score} + score_inc;
        score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            step_q  <= '0;
            pattern <= '0;
            win_cnt <= '0;
            arrows  <= '0;
            hit     <= 1'b0;
            miss    <= 1'b0;
            score   <= '0;
            combo   <= '0;
        end else begin
            step_q <= step;
            hit    <= judge_hit;
            miss   <= judge_miss;

            if (judge_hit) begin
                score <= score_next;
                combo <= (combo == 4'd15) ? combo : combo + 4'd1;
            end else if (judge_miss) begin
                combo <= '0;
            end

            if (beat) begin
                pattern <= rom_pat;
                win_cnt <= '0;
                state   <= ARMED;
                arrows  <= rom_pat;
            end else begin
                case (state)
                    ARMED: begin
                        if (judge_hit || judge_miss) begin
                            state  <= DONE;
                            arrows <= '0;
                        end else begin
                            win_cnt <= win_cnt + 4'd1;
                        end
                    end
                    default: arrows <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dance_step_judge.sv
// Directed bench for dance_step_judge: vector table plus sequences for combo, saturation and reset.
module tb_dance_step_judge;

    logic       Clock;
    logic       reset;
    logic [2:0] step;
    logic [3:0] pads;
    logic [3:0] arrows;
    logic       hit;
    logic       miss;
    logic [7:0] score;
    logic [3:0] combo;

    int total = 0;
    int bad   = 0;
    int exp_score = 0;
    int exp_combo = 0;
    logic [2:0] cur_step = '0;

    dance_step_judge #(.WINDOW(4), .SCORE_W(8)) dut (
        .Clock (Clock),
        .reset (reset),
        .step  (step),
        .pads  (pads),
        .arrows(arrows),
        .hit   (hit),
        .miss  (miss),
        .score (score),
        .combo (combo)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0] s;
        logic [3:0] p;
        logic [3:0] a;
        logic       h;
        logic       m;
        logic [7:0] sc;
        logic [3:0] cb;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [3:0] rom(input logic [2:0] s);
        case (s)
            3'd0: return 4'b0001;
            3'd1: return 4'b0010;
            3'd2: return 4'b0100;
            3'd3: return 4'b1000;
            3'd4: return 4'b0011;
            3'd5: return 4'b1100;
            3'd6: return 4'b0101;
            default: return 4'b1010;
        endcase
    endfunction

    function automatic int next_inc();
`ifdef COMBO_BONUS_EN
        if (exp_combo >= 3) return 2;
`endif
        return 1;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] a, input logic h, input logic m,
                           input logic [7:0] sc, input logic [3:0] cb);
        chk({name, ".arrows"}, 32'(arrows), 32'(a));
        chk({name, ".hit"},    32'(hit),    32'(h));
        chk({name, ".miss"},   32'(miss),   32'(m));
        chk({name, ".score"},  32'(score),  32'(sc));
        chk({name, ".combo"},  32'(combo),  32'(cb));
        chk({name, ".excl"},   32'(hit & miss), 32'd0);
    endtask

    task automatic addv(input logic [2:0] s, input logic [3:0] p, input logic [3:0] a,
                        input logic h, input logic m, input logic [7:0] sc, input logic [3:0] cb);
        vec_t v;
        v.s = s; v.p = p; v.a = a; v.h = h; v.m = m; v.sc = sc; v.cb = cb;
        vecs.push_back(v);
    endtask

    task automatic do_hit();
        logic [2:0] s;
        int inc;
        s = cur_step + 3'd1;
        step = s;
        pads = 4'b0000;
        tick();
        chk("hit_arm.arrows", 32'(arrows), 32'(rom(s)));
        pads = rom(s);
        inc = next_inc();
        exp_score = (exp_score + inc > 255) ? 255 : exp_score + inc;
        exp_combo = (exp_combo == 15) ? 15 : exp_combo + 1;
        tick();
        chk_all("hit_seq", 4'b0000, 1'b1, 1'b0, 8'(exp_score), 4'(exp_combo));
        pads = 4'b0000;
        cur_step = s;
    endtask

    task automatic do_miss();
        logic [2:0] s;
        s = cur_step + 3'd1;
        step = s;
        pads = 4'b0000;
        tick();
        pads = ~rom(s);
        exp_combo = 0;
        tick();
        chk_all("miss_seq", 4'b0000, 1'b0, 1'b1, 8'(exp_score), 4'd0);
        pads = 4'b0000;
        cur_step = s;
    endtask

    initial begin
        int start_score;
        int guard;

        reset = 1'b1;
        step  = 3'd0;
        pads  = 4'b0000;
        tick();
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 8'd0, 4'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("idle_hold", 4'b0000, 1'b0, 1'b0, 8'd0, 4'd0);
        end

        //   step  pads     arrows   hit   miss  score combo
        addv(3'd1, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'd0, 4'd0);
        addv(3'd1, 4'b0000, 4'b0010, 1'b0, 1'b0, 8'd0, 4'd0);
        addv(3'd1, 4'b0010, 4'b0000, 1'b1, 1'b0, 8'd1, 4'd1);
        addv(3'd1, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1, 4'd1);
        addv(3'd2, 4'b0000, 4'b0100, 1'b0, 1'b0, 8'd1, 4'd1);
        addv(3'd2, 4'b0001, 4'b0000, 1'b0, 1'b1, 8'd1, 4'd0);
        addv(3'd2, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1, 4'd0);
        addv(3'd3, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'd1, 4'd0);
        addv(3'd3, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'd1, 4'd0);
        addv(3'd3, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'd1, 4'd0);
        addv(3'd3, 4'b0000, 4'b1000, 1'b0, 1'b0, 8'd1, 4'd0);
        addv(3'd3, 4'b0000, 4'b0000, 1'b0, 1'b1, 8'd1, 4'd0);
        addv(3'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd1, 4'd0);
        addv(3'd4, 4'b0000, 4'b0011, 1'b0, 1'b0, 8'd1, 4'd0);
        addv(3'd4, 4'b0001, 4'b0011, 1'b0, 1'b0, 8'd1, 4'd0);
        addv(3'd4, 4'b0011, 4'b0000, 1'b1, 1'b0, 8'd2, 4'd1);
        addv(3'd4, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd2, 4'd1);
        // beat while armed with no press: old beat missed, new one armed on the same edge
        addv(3'd5, 4'b0000, 4'b1100, 1'b0, 1'b0, 8'd2, 4'd1);
        addv(3'd6, 4'b0000, 4'b0101, 1'b0, 1'b1, 8'd2, 4'd0);
        addv(3'd6, 4'b0101, 4'b0000, 1'b1, 1'b0, 8'd3, 4'd1);
        addv(3'd6, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd3, 4'd1);
        // beat together with exact match: hit credited to old pattern
        addv(3'd7, 4'b0000, 4'b1010, 1'b0, 1'b0, 8'd3, 4'd1);
        addv(3'd0, 4'b1010, 4'b0001, 1'b1, 1'b0, 8'd4, 4'd2);
        addv(3'd0, 4'b0000, 4'b0001, 1'b0, 1'b0, 8'd4, 4'd2);
        addv(3'd0, 4'b0001, 4'b0000, 1'b1, 1'b0, 8'd5, 4'd3);
        addv(3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 8'd5, 4'd3);

        foreach (vecs[i]) begin
            step = vecs[i].s;
            pads = vecs[i].p;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].h, vecs[i].m, vecs[i].sc, vecs[i].cb);
        end

        exp_score = 5;
        exp_combo = 3;
        cur_step  = 3'd0;
        pads      = 4'b0000;

        do_miss();
        start_score = exp_score;
        for (int i = 0; i < 5; i++) do_hit();
`ifdef COMBO_BONUS_EN
        chk("five_hits.score", 32'(score), 32'(start_score + 7));
`else
        chk("five_hits.score", 32'(score), 32'(start_score + 5));
`endif
        chk("five_hits.combo", 32'(combo), 32'd5);

        guard = 0;
        while (exp_score < 254 && guard < 1000) begin
            if (exp_score + next_inc() > 254) do_miss();
            else do_hit();
            guard++;
        end
        chk("pre_sat.score", 32'(score), 32'd254);
        do_hit();
        chk("sat1.score", 32'(score), 32'd255);
        do_hit();
        chk("sat2.score", 32'(score), 32'd255);
        chk("combo_sat", 32'(combo), 32'd15);

        step = cur_step + 3'd1;
        tick();
        chk("armed_before_reset", 32'(arrows), 32'(rom(step)));
        #2;
        reset = 1'b1;
        step  = 3'd0;
        #1;
        chk_all("async_reset", 4'b0000, 1'b0, 1'b0, 8'd0, 4'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("post_reset", 4'b0000, 1'b0, 1'b0, 8'd0, 4'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
